// File: rtl/xrdstream.sv
// xrdstream: read-side stream stage behind the 3-level address generator.
//   Issues registered memory reads, realigns returning data with a valid
//   strobe over a fixed MEM_LAT read latency, counts delivered words and
//   reports done only once no reads are left in flight.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   run_i                         start pulse; restarts the stream from any state
//   ag_addr_i, ag_mem_en_i        read address / request from the generator
//   ag_done_i                     generator finished issuing requests
//   pad_bound_i                   requests with address >= bound are padding
//                                 (present only with XRDSTREAM_PAD_EN defined)
//   mem_addr_o, mem_en_o          registered memory read port
//   mem_data_i                    read data, valid MEM_LAT cycles after mem_en_o
//   data_out_o, valid_out_o       aligned read data and its one-cycle strobe
//   word_cnt_o                    valid beats since the last run, wrapping
//   done_o                        high in IDLE: stream over and pipeline empty
// Optional feature macro: XRDSTREAM_PAD_EN.
module xrdstream #(
   parameter int MEM_ADDR_W = 10,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_i,
   input  logic [MEM_ADDR_W-1:0] ag_addr_i,
   input  logic                  ag_mem_en_i,
   input  logic                  ag_done_i,
`ifdef XRDSTREAM_PAD_EN
   input  logic [MEM_ADDR_W-1:0] pad_bound_i,
`endif
   output logic [MEM_ADDR_W-1:0] mem_addr_o,
   output logic                  mem_en_o,
   input  logic [DATA_W-1:0]     mem_data_i,
   output logic [DATA_W-1:0]     data_out_o,
   output logic                  valid_out_o,
   output logic [CNT_W-1:0]      word_cnt_o,
   output logic                  done_o
);
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
   state_t                state_q, state_d;
   logic [MEM_LAT:0]      tag_q, tag_d;
   logic [MEM_ADDR_W-1:0] addr_q, addr_d;
   logic                  en_q, en_d, valid_q, valid_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  beat, is_pad, out_pad;

`ifdef XRDSTREAM_PAD_EN
   // Pad marks travel alongside the tags so a padded beat keeps the same
   // latency as a real read but never touches memory.
   logic [MEM_LAT:0] pad_q, pad_d;
   assign is_pad  = ag_mem_en_i && (ag_addr_i >= pad_bound_i);
   assign out_pad = pad_q[MEM_LAT];
   assign pad_d   = run_i ? '0 : {pad_q[MEM_LAT-1:0], is_pad};
   always_ff @(posedge clk or posedge rst)
      if (rst) pad_q <= '0;
      else     pad_q <= pad_d;
`else
   assign is_pad  = 1'b0;
   assign out_pad = 1'b0;
`endif

   // A run discards whatever is still in flight, including a beat that
   // would otherwise be delivered on this very edge.
   assign beat = tag_q[MEM_LAT] && !run_i;

   always_comb begin
      state_d = state_q;
      if (run_i)
         state_d = STREAM;
      else if (state_q == STREAM && ag_done_i)
         state_d = DRAIN;
      else if (state_q == DRAIN && tag_q == '0 && !ag_mem_en_i)
         state_d = IDLE;
      tag_d   = run_i ? '0 : {tag_q[MEM_LAT-1:0], ag_mem_en_i};
      addr_d  = ag_mem_en_i ? ag_addr_i : addr_q;
      en_d    = ag_mem_en_i && !is_pad;
      valid_d = beat;
      data_d  = beat ? (out_pad ? '0 : mem_data_i) : data_q;
      cnt_d   = run_i ? '0 : cnt_q + CNT_W'(beat);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         tag_q   <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end

   assign mem_addr_o  = addr_q;
   assign mem_en_o    = en_q;
   assign data_out_o  = data_q;
   assign valid_out_o = valid_q;
   assign word_cnt_o  = cnt_q;
   assign done_o      = (state_q == IDLE);
endmodule

// File: tb/tb_xrdstream.sv
// tb_xrdstream: self-checking bench for xrdstream (MEM_LAT=2, CNT_W=3).
//   Table-driven latency/drain vectors, hand sequences for restart, reset,
//   wrap and padding, then randomized traffic against a delivery-queue model.
module tb_xrdstream;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int L  = 2;
   localparam int CW = 3;
`ifdef XRDSTREAM_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic          clk = 1'b0, rst = 1'b1, run = 1'b0, en = 1'b0, agd = 1'b0;
   logic [AW-1:0] addr = '0, pb = '1;
   logic [AW-1:0] mem_addr;
   logic          mem_en, valid, done;
   logic [DW-1:0] mem_data, data_out;
   logic [CW-1:0] cnt;
   logic [DW-1:0] pipe [L];

   always #5 clk = ~clk;

   // Memory with MEM_LAT cycles of read latency holding addr*10.
   always @(posedge clk) begin
      pipe[0] <= DW'(mem_addr) * DW'(10);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
   end
   assign mem_data = pipe[L-1];

   xrdstream #(.MEM_ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .run_i(run), .ag_addr_i(addr), .ag_mem_en_i(en),
      .ag_done_i(agd),
`ifdef XRDSTREAM_PAD_EN
      .pad_bound_i(pb),
`endif
      .mem_addr_o(mem_addr), .mem_en_o(mem_en), .mem_data_i(mem_data),
      .data_out_o(data_out), .valid_out_o(valid), .word_cnt_o(cnt),
      .done_o(done));

   int checks = 0, errors = 0;

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: every accepted request becomes a pending delivery due
   // MEM_LAT+2 cycles later; a run throws all pending deliveries away.
   typedef struct {int due; logic [DW-1:0] d;} ent_t;
   ent_t          q[$];
   int            cyc = 0;
   bit            busy, drn, m_en, m_valid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_cnt;

   function automatic void model_reset();
      q.delete();
      busy = 0; drn = 0; m_en = 0; m_valid = 0; m_addr = '0; m_data = '0; m_cnt = 0;
   endfunction

   task automatic drive(bit r, bit e, bit d, int a);
      run = r; en = e; agd = d; addr = AW'(a);
   endtask

   task automatic step();
      bit   empty, pad;
      ent_t e;
      empty = (q.size() == 0);
      pad = PAD && en && (addr >= pb);
      m_en = en && !pad;
      if (en) m_addr = addr;
      m_valid = 0;
      if (run) begin
         q.delete();
         m_cnt = 0;
      end else if (q.size() > 0 && q[0].due == cyc + 1) begin
         m_valid = 1;
         m_data = q[0].d;
         m_cnt = (m_cnt + 1) % (1 << CW);
         void'(q.pop_front());
      end
      if (en && !run) begin
         e.due = cyc + L + 2;
         e.d = pad ? '0 : DW'(addr) * DW'(10);
         q.push_back(e);
      end
      if (run) begin busy = 1; drn = 0; end
      else if (busy && !drn && agd) drn = 1;
      else if (drn && empty && !en) begin busy = 0; drn = 0; end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_model(string tag);
      chk({tag, "_mem_addr"}, mem_addr, m_addr);
      chk({tag, "_mem_en"}, mem_en, m_en);
      chk({tag, "_valid"}, valid, m_valid);
      chk({tag, "_data"}, data_out, m_data);
      chk({tag, "_cnt"}, cnt, m_cnt);
      chk({tag, "_done"}, done, !busy);
   endtask

   typedef struct {
      bit run, en, agd; int addr;
      int x_addr; bit x_en, x_valid; int x_data, x_cnt; bit x_done;
   } vec_t;
   vec_t tv[11];

   initial begin
      #200000;
      $display("FAIL timeout got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      int nb, first, last, nen;
      logic [DW-1:0] dq[$];
      // latency/drain: run c0, reads addr 0..3 c1..c4, ag_done from c5
      tv[0]  = '{1,0,0,0, 0,0,0, 0,0,1};
      tv[1]  = '{0,1,0,0, 0,0,0, 0,0,0};
      tv[2]  = '{0,1,0,1, 0,1,0, 0,0,0};
      tv[3]  = '{0,1,0,2, 1,1,0, 0,0,0};
      tv[4]  = '{0,1,0,3, 2,1,0, 0,0,0};
      tv[5]  = '{0,0,1,7, 3,1,1, 0,1,0};
      tv[6]  = '{0,0,1,7, 3,0,1,10,2,0};
      tv[7]  = '{0,0,1,7, 3,0,1,20,3,0};
      tv[8]  = '{0,0,1,7, 3,0,1,30,4,0};
      tv[9]  = '{0,0,1,7, 3,0,0,30,4,1};
      tv[10] = '{0,0,0,7, 3,0,0,30,4,1};

      model_reset();
      #1;
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_data", data_out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_done", done, 1);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         drive(tv[i].run, tv[i].en, tv[i].agd, tv[i].addr);
         chk($sformatf("lat%0d_mem_addr", i), mem_addr, tv[i].x_addr);
         chk($sformatf("lat%0d_mem_en", i), mem_en, tv[i].x_en);
         chk($sformatf("lat%0d_valid", i), valid, tv[i].x_valid);
         chk($sformatf("lat%0d_data", i), data_out, tv[i].x_data);
         chk($sformatf("lat%0d_cnt", i), cnt, tv[i].x_cnt);
         chk($sformatf("lat%0d_done", i), done, tv[i].x_done);
         step();
      end

      // restart with two reads in flight
      drive(1, 0, 0, 0); step();
      drive(0, 1, 0, 4); step();
      drive(0, 1, 0, 5); step();
      drive(1, 0, 0, 0); step();
      chk("restart_valid_c4", valid, 0);
      chk("restart_cnt", cnt, 0);
      chk("restart_done", done, 0);
      drive(0, 1, 0, 6); step();
      chk("restart_valid_c5", valid, 0);
      drive(0, 1, 0, 7); step();
      chk("restart_valid_c6", valid, 0);
      check_model("restart_c6");
      drive(0, 0, 1, 0); step();
      chk("restart_valid_c7", valid, 0);
      step();
      chk("restart_valid_c8", valid, 1);
      chk("restart_data_c8", data_out, 60);
      chk("restart_cnt_c8", cnt, 1);
      step();
      chk("restart_data_c9", data_out, 70);
      chk("restart_cnt_c9", cnt, 2);
      chk("restart_done_c9", done, 0);
      step();
      chk("restart_done_c10", done, 1);
      chk("restart_valid_c10", valid, 0);

      // asynchronous reset mid-stream
      drive(1, 0, 0, 0); step();
      drive(0, 1, 0, 1); step();
      drive(0, 1, 0, 2); step();
      #2 rst = 1'b1;
      #1;
      chk("arst_mem_addr", mem_addr, 0);
      chk("arst_mem_en", mem_en, 0);
      chk("arst_data", data_out, 0);
      chk("arst_valid", valid, 0);
      chk("arst_cnt", cnt, 0);
      chk("arst_done", done, 1);
      drive(0, 0, 0, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk("arst_post_done", done, 1);
      chk("arst_post_valid", valid, 0);

      // counter wrap: 10 back-to-back reads with CNT_W=3
      nb = 0; first = -1; last = -1;
      for (int i = 0; i < 40; i++) begin
         drive(i == 0, i >= 1 && i <= 10, i >= 11, (i >= 1 && i <= 10) ? i - 1 : 0);
         step();
         check_model("wrap");
         if (valid) begin
            nb++;
            if (first < 0) first = i;
            last = i;
         end
         if (i > 11 && done) break;
      end
      chk("wrap_cnt", cnt, 2);
      chk("wrap_beats", nb, 10);
      chk("wrap_span", last - first + 1, 10);
      chk("wrap_done", done, 1);

`ifdef XRDSTREAM_PAD_EN
      // padding: bound 2, addresses 0..3
      pb = AW'(2);
      nen = 0;
      for (int i = 0; i < 20; i++) begin
         drive(i == 0, i >= 1 && i <= 4, i >= 5, (i >= 1 && i <= 4) ? i - 1 : 0);
         step();
         check_model("pad");
         if (mem_en) nen++;
         if (valid) dq.push_back(data_out);
      end
      chk("pad_mem_en_count", nen, 2);
      chk("pad_beats", dq.size(), 4);
      if (dq.size() == 4) begin
         chk("pad_data0", dq[0], 0);
         chk("pad_data1", dq[1], 10);
         chk("pad_data2", dq[2], 0);
         chk("pad_data3", dq[3], 0);
      end
      chk("pad_cnt", cnt, 4);
      pb = '1;
`endif

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bit r;
         r = ($urandom_range(0, 29) == 0);
         drive(r, !r && $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
               int'($urandom_range(0, 15)));
         if (PAD && $urandom_range(0, 15) == 0) pb = AW'($urandom_range(0, 16));
         step();
         check_model("rand");
      end
      for (int i = 0; i < 50 && !done; i++) begin
         drive(0, 0, 1, 0);
         step();
         check_model("rand_drain");
      end
      chk("final_done", done, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
